// File: rtl/hdmi_pixel_fetch.sv
// Frame-buffer read stage for the HDMI path: bursts RGB565 pixels from memory into a
// local FIFO and hands one pixel per data_req cycle, restarting at FRAME_BASE on every vsync.
module hdmi_pixel_fetch #(
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0,
  parameter int unsigned       FIFO_DEPTH = 64,
  parameter int unsigned       BURST_LEN  = 16
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic              video_vs,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic              data_req,
  output logic [15:0]       data_out,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              underflow
);

  localparam int unsigned     PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned     CW       = PW + 1;
  localparam logic [CW-1:0]   FREE_LIM = CW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [21:0]     BURST_W  = 22'(BURST_LEN);

  // IDLE: wait for space | REQ: rd_req held | WAIT: store beats | DRAIN: discard beats | FLUSH: frame restart
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic                vs_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [21:0]         words_left_q;
  logic [7:0]          beat_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [7:0]          rd_len_q;
  logic [15:0]         data_out_q;
  logic                underflow_q;
  logic [15:0]         fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;

  logic                vs_fall, last_beat, fifo_empty, fifo_full, free_ok, fetch_go, pop;
  logic                req_out, fifo_wr, flush, beat_clr, beat_inc, burst_done;
  logic [7:0]          burst_len_d;

  assign vs_fall     = vs_q & ~video_vs;
  assign last_beat   = rd_valid && (beat_q == rd_len_q - 8'd1);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_CNT);
  // Nothing is outstanding while IDLE, so free space reduces to depth minus stored words.
  assign free_ok     = (count_q <= FREE_LIM);
  assign fetch_go    = (state_q == S_IDLE) && !vs_fall && (words_left_q != '0) && free_ok;
  assign burst_len_d = (words_left_q < BURST_W) ? words_left_q[7:0] : BURST_W[7:0];
  assign pop         = data_req && !fifo_empty;

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (vs_fall)       state_d = S_FLUSH;
        else if (fetch_go) state_d = S_REQ;
      end
      S_REQ: begin
        if (rd_ack)        state_d = vs_fall ? S_DRAIN : S_WAIT;
        else if (vs_fall)  state_d = S_FLUSH;
      end
      S_WAIT: begin
        if (last_beat)     state_d = vs_fall ? S_FLUSH : S_IDLE;
        else if (vs_fall)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_beat)     state_d = S_FLUSH;
      end
      S_FLUSH:             state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_out    = 1'b0;
    fifo_wr    = 1'b0;
    flush      = 1'b0;
    beat_clr   = 1'b0;
    beat_inc   = 1'b0;
    burst_done = 1'b0;
    case (state_q)
      S_REQ: begin
        req_out  = 1'b1;
        beat_clr = rd_ack;
      end
      S_WAIT: begin
        fifo_wr    = rd_valid && !fifo_full;
        beat_inc   = rd_valid;
        burst_done = last_beat;
      end
      S_DRAIN:  beat_inc = rd_valid;
      S_FLUSH:  flush    = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      vs_q         <= 1'b0;
      addr_q       <= FRAME_BASE;
      words_left_q <= '0;
      beat_q       <= '0;
      rd_addr_q    <= FRAME_BASE;
      rd_len_q     <= '0;
      data_out_q   <= '0;
      underflow_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      vs_q <= video_vs;

      if (fetch_go) begin
        rd_addr_q <= addr_q;
        rd_len_q  <= burst_len_d;
      end

      if (beat_clr)      beat_q <= '0;
      else if (beat_inc) beat_q <= beat_q + 8'd1;

      if (flush) begin
        addr_q       <= FRAME_BASE;
        words_left_q <= 22'(h_disp) * 22'(v_disp);
      end else if (burst_done) begin
        addr_q       <= addr_q + ADDR_W'(rd_len_q);
        words_left_q <= words_left_q - 22'(rd_len_q);
      end

      if (pop)           data_out_q <= fifo_mem_q[rd_ptr_q];
      else if (data_req) data_out_q <= '0;

      if (flush)                       underflow_q <= 1'b0;
      else if (data_req && fifo_empty) underflow_q <= 1'b1;

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (fifo_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({fifo_wr, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= rd_data;
  end

  assign data_out  = data_out_q;
  assign rd_req    = req_out;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign underflow = underflow_q;

endmodule
